// File: rtl/qpsk_pkg.sv
// Shared constants for the 8-chip QPSK demap path: state encoding, symbol
// length, sync pattern and the four chip patterns with their dibit map.
package qpsk_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } qpsk_state_t;

   localparam int CHIPS_PER_SYM = 8;
   localparam logic [2:0] LAST_POS = 3'(CHIPS_PER_SYM - 1);

   localparam logic [7:0] PAT_D00  = 8'b11110000;
   localparam logic [7:0] PAT_D01  = 8'b11000011;
   localparam logic [7:0] PAT_D10  = 8'b00001111;
   localparam logic [7:0] PAT_D11  = 8'b00111100;
   localparam logic [7:0] SYNC_PAT = PAT_D00;

   // 4-bit up-count that sticks at its maximum instead of wrapping
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/qpsk_sync_ctrl_if.sv
// Chip input and symbol output bundle of the QPSK sync controller.
interface qpsk_sync_ctrl_if;
   logic       chip_en;
   logic       x;
   logic       sym_stb;
   logic [1:0] dibit;
   logic       dibit_vld;
   logic       sym_err;
   logic       locked;
   logic [1:0] state;

   modport master (
      output chip_en, x,
      input  sym_stb, dibit, dibit_vld, sym_err, locked, state
   );

   modport slave (
      input  chip_en, x,
      output sym_stb, dibit, dibit_vld, sym_err, locked, state
   );
endinterface

// File: rtl/qpsk_chip_demap.sv
// Combinational 8-chip window decoder: valid flag plus dibit for the four
// legal chip patterns; any other window is reported invalid with dibit 00.
module qpsk_chip_demap
   import qpsk_pkg::*;
(
   input  logic [7:0] win,
   output logic       valid,
   output logic [1:0] dibit
);

   // pattern lookup
   always_comb begin
      valid = 1'b1;
      dibit = 2'b00;
      case (win)
         PAT_D00: dibit = 2'b00;
         PAT_D01: dibit = 2'b01;
         PAT_D10: dibit = 2'b10;
         PAT_D11: dibit = 2'b11;
         default: begin
            valid = 1'b0;
            dibit = 2'b00;
         end
      endcase
   end

endmodule

// File: rtl/qpsk_sync_ctrl.sv
// Symbol-timing and lock controller: hunts for SYNC, verifies it over
// LOCK_HITS symbols, then demaps one dibit per 8 chips until LOSS_MISSES misses.
module qpsk_sync_ctrl
   import qpsk_pkg::*;
#(
   parameter int LOCK_HITS   = 4,
   parameter int LOSS_MISSES = 3
)(
   input  logic          clk,
   input  logic          reset,
   qpsk_sync_ctrl_if.slave bus
);

   localparam logic [3:0] LOCK_HITS_C   = 4'(LOCK_HITS);
   localparam logic [3:0] LOSS_MISSES_C = 4'(LOSS_MISSES);

   // The window always contains this cycle's chip, so only 7 past chips are kept
   logic [6:0]  sr_r,     sr_nxt;
   logic [2:0]  pos_r,    pos_nxt;
   logic [3:0]  hit_r,    hit_nxt;
   logic [3:0]  miss_r,   miss_nxt;
   qpsk_state_t state_r,  state_nxt;
   logic        stb_r,    stb_nxt;
   logic [1:0]  dibit_r,  dibit_nxt;
   logic        vld_r,    vld_nxt;
   logic        err_r,    err_nxt;
   logic        locked_r, locked_nxt;

   logic [7:0]  win;
   logic        boundary;
   logic        dm_valid;
   logic [1:0]  dm_dibit;

   assign win      = {sr_r, bus.x};
   assign boundary = bus.chip_en && (pos_r == LAST_POS);

   qpsk_chip_demap u_demap (
      .win   (win),
      .valid (dm_valid),
      .dibit (dm_dibit)
   );

   // next-state, counters and output decisions
   always_comb begin
      sr_nxt     = sr_r;
      pos_nxt    = pos_r;
      hit_nxt    = hit_r;
      miss_nxt   = miss_r;
      state_nxt  = state_r;
      stb_nxt    = 1'b0;
      dibit_nxt  = dibit_r;
      vld_nxt    = 1'b0;
      err_nxt    = 1'b0;
      if (bus.chip_en) begin
         sr_nxt  = win[6:0];
         pos_nxt = pos_r + 3'd1;
         case (state_r)
            ST_SEARCH: begin
               if (win == SYNC_PAT) begin
                  pos_nxt   = 3'd0;
                  hit_nxt   = 4'd1;
                  miss_nxt  = 4'd0;
                  state_nxt = (LOCK_HITS == 1) ? ST_LOCKED : ST_VERIFY;
               end else begin
                  hit_nxt  = 4'd0;
                  miss_nxt = 4'd0;
               end
            end
            ST_VERIFY: begin
               if (boundary && (win == SYNC_PAT)) begin
                  hit_nxt = sat_inc4(hit_r);
                  if (hit_nxt >= LOCK_HITS_C) begin
                     state_nxt = ST_LOCKED;
                     miss_nxt  = 4'd0;
                  end else begin
                     state_nxt = ST_VERIFY;
                  end
               end else if (boundary) begin
                  state_nxt = ST_SEARCH;
                  pos_nxt   = 3'd0;
                  hit_nxt   = 4'd0;
                  miss_nxt  = 4'd0;
               end else begin
                  state_nxt = ST_VERIFY;
               end
            end
            ST_LOCKED: begin
               if (boundary) begin
                  stb_nxt = 1'b1;
                  if (dm_valid) begin
                     dibit_nxt = dm_dibit;
                     vld_nxt   = 1'b1;
                     miss_nxt  = 4'd0;
                  end else begin
                     err_nxt  = 1'b1;
                     miss_nxt = sat_inc4(miss_r);
                     if (miss_nxt >= LOSS_MISSES_C) begin
                        state_nxt = ST_SEARCH;
                        pos_nxt   = 3'd0;
                        hit_nxt   = 4'd0;
                        miss_nxt  = 4'd0;
                     end else begin
                        state_nxt = ST_LOCKED;
                     end
                  end
               end else begin
                  state_nxt = ST_LOCKED;
               end
            end
            default: begin
               state_nxt = ST_SEARCH;
               pos_nxt   = 3'd0;
               hit_nxt   = 4'd0;
               miss_nxt  = 4'd0;
            end
         endcase
      end else begin
         sr_nxt = sr_r;
      end
      locked_nxt = (state_nxt == ST_LOCKED);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_r     <= 7'd0;
         pos_r    <= 3'd0;
         hit_r    <= 4'd0;
         miss_r   <= 4'd0;
         state_r  <= ST_SEARCH;
         stb_r    <= 1'b0;
         dibit_r  <= 2'b00;
         vld_r    <= 1'b0;
         err_r    <= 1'b0;
         locked_r <= 1'b0;
      end else begin
         sr_r     <= sr_nxt;
         pos_r    <= pos_nxt;
         hit_r    <= hit_nxt;
         miss_r   <= miss_nxt;
         state_r  <= state_nxt;
         stb_r    <= stb_nxt;
         dibit_r  <= dibit_nxt;
         vld_r    <= vld_nxt;
         err_r    <= err_nxt;
         locked_r <= locked_nxt;
      end
   end

   assign bus.sym_stb   = stb_r;
   assign bus.dibit     = dibit_r;
   assign bus.dibit_vld = vld_r;
   assign bus.sym_err   = err_r;
   assign bus.locked    = locked_r;
   assign bus.state     = state_r;

endmodule

// File: tb/tb_qpsk_sync_ctrl.sv
// Scoreboard bench for qpsk_sync_ctrl: a symbol-level reference model queues
// expected per-cycle status and per-strobe symbols; a monitor pops and compares.
module tb_qpsk_sync_ctrl;

   localparam int LH = 4;
   localparam int LM = 3;

   typedef struct {
      logic       stb;
      logic [1:0] dibit;
      logic       vld;
      logic       err;
      logic       locked;
      logic [1:0] state;
   } cyc_t;

   typedef struct {
      logic [1:0] dibit;
      logic       vld;
      logic       err;
   } sym_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   qpsk_sync_ctrl_if bus ();

   qpsk_sync_ctrl #(.LOCK_HITS(LH), .LOSS_MISSES(LM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   cyc_t cyc_q[$];
   sym_t sym_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model: mode 0 hunting, 1 confirming, 2 locked
   int       m_mode = 0;
   bit [7:0] m_hist = 8'h00;
   int       m_since = 0;
   int       m_hits = 0;
   int       m_misses = 0;
   bit [1:0] m_dibit = 2'b00;
   bit [7:0] pats [4] = '{8'hF0, 8'hC3, 8'h0F, 8'h3C};

   function automatic int decode(input bit [7:0] w);
      for (int i = 0; i < 4; i++)
         if (w == pats[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit xv);
      cyc_t c;
      sym_t s;
      bit [7:0] w;
      int d;
      c.stb = 1'b0; c.vld = 1'b0; c.err = 1'b0;
      if (rst) begin
         m_mode = 0; m_hist = 8'h00; m_since = 0; m_hits = 0; m_misses = 0; m_dibit = 2'b00;
      end else if (en) begin
         w = {m_hist[6:0], xv};
         m_hist = w;
         if (m_mode == 0) begin
            if (w == 8'hF0) begin
               m_since = 0; m_hits = 1;
               m_mode = (LH == 1) ? 2 : 1;
            end
         end else begin
            m_since++;
            if (m_since == 8) begin
               m_since = 0;
               if (m_mode == 1) begin
                  if (w == 8'hF0) begin
                     m_hits = (m_hits < 15) ? m_hits + 1 : 15;
                     if (m_hits >= LH) begin m_mode = 2; m_misses = 0; end
                  end else begin
                     m_mode = 0; m_hits = 0; m_misses = 0;
                  end
               end else begin
                  c.stb = 1'b1;
                  d = decode(w);
                  if (d >= 0) begin
                     m_dibit = 2'(d); c.vld = 1'b1; m_misses = 0;
                  end else begin
                     c.err = 1'b1;
                     m_misses = (m_misses < 15) ? m_misses + 1 : 15;
                     if (m_misses >= LM) begin m_mode = 0; m_hits = 0; m_misses = 0; end
                  end
                  s.dibit = m_dibit; s.vld = c.vld; s.err = c.err;
                  sym_q.push_back(s);
               end
            end
         end
      end
      c.dibit  = m_dibit;
      c.locked = (m_mode == 2);
      c.state  = 2'(m_mode);
      cyc_q.push_back(c);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // monitor: compare DUT outputs against queued expectations after each edge
   initial begin
      cyc_t c;
      sym_t s;
      forever begin
         @(posedge clk);
         #1;
         if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("sym_stb", int'(bus.sym_stb), int'(c.stb));
            chk("dibit",   int'(bus.dibit),   int'(c.dibit));
            chk("locked",  int'(bus.locked),  int'(c.locked));
            chk("state",   int'(bus.state),   int'(c.state));
            chk("vld_err_excl", int'(bus.dibit_vld & bus.sym_err), 0);
            if (bus.sym_stb === 1'b1) begin
               if (sym_q.size() == 0) begin
                  chk("unexpected_strobe", 1, 0);
               end else begin
                  s = sym_q.pop_front();
                  chk("sym_dibit", int'(bus.dibit),     int'(s.dibit));
                  chk("dibit_vld", int'(bus.dibit_vld), int'(s.vld));
                  chk("sym_err",   int'(bus.sym_err),   int'(s.err));
               end
            end else begin
               chk("idle_vld", int'(bus.dibit_vld), int'(c.vld));
               chk("idle_err", int'(bus.sym_err),   int'(c.err));
            end
         end
      end
   end

   task automatic drive(input bit rst, input bit en, input bit xv);
      @(negedge clk);
      reset = rst;
      bus.chip_en = en;
      bus.x = xv;
      model_step(rst, en, xv);
   endtask

   // enmode 0: every cycle; 1: alternate with idle cycles; 2: random gaps
   task automatic send_sym(input logic [7:0] pat, input int enmode);
      for (int i = 7; i >= 0; i--) begin
         if (enmode == 2) begin
            while ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end
         drive(1'b0, 1'b1, pat[i]);
         if (enmode == 1) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic send_n(input logic [7:0] pat, input int n, input int enmode);
      for (int k = 0; k < n; k++) send_sym(pat, enmode);
   endtask

   task automatic chips(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      int k;
      logic [7:0] p;
      bus.chip_en = 1'b0;
      bus.x = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // acquisition, data patterns, miss handling and loss of lock
      send_n(8'hF0, 5, 0);
      send_sym(8'hC3, 0); send_sym(8'h0F, 0); send_sym(8'h3C, 0);
      send_n(8'hAA, 2, 0); send_sym(8'hF0, 0); send_n(8'hAA, 3, 0);
      chips(4);

      // false start: SYNC followed by a corrupted symbol
      drive(1'b1, 1'b0, 1'b0);
      chips(3); send_sym(8'hF0, 0); send_sym(8'hF1, 0);
      chips(5);

      // gapped chip enables
      drive(1'b1, 1'b0, 1'b0);
      send_n(8'hF0, 5, 1);
      send_sym(8'hC3, 1); send_sym(8'h0F, 1); send_sym(8'h3C, 1);

      // reset mid-verify and mid-symbol while locked, reset wins over chip_en
      drive(1'b1, 1'b0, 1'b0);
      send_n(8'hF0, 2, 0); chips(3);
      drive(1'b1, 1'b1, 1'b1);
      send_n(8'hF0, 4, 0); send_sym(8'h3C, 0); chips(3);
      drive(1'b1, 1'b1, 1'b0);
      send_n(8'hF0, 3, 0); send_sym(8'hC3, 0);

      // randomized rounds: lock, then a mix of valid, invalid and slipped symbols
      for (int r = 0; r < 8; r++) begin
         send_n(8'hF0, $urandom_range(3, 5), $urandom_range(0, 2));
         for (int j = 0; j < 12; j++) begin
            k = $urandom_range(0, 11);
            if (k < 4) p = pats[k];
            else if (k < 6) p = 8'hF0;
            else if (k == 6) p = 8'($urandom);
            else if (k == 7) p = 8'hAA;
            else if (k == 8) begin p = 8'hF0; chips(1); end
            else if (k == 9 && $urandom_range(0, 3) == 0) begin p = 8'h0F; drive(1'b1, 1'b1, 1'b1); end
            else p = pats[$urandom_range(0, 3)];
            send_sym(p, $urandom_range(0, 2));
         end
      end

      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("cyc_queue_drained", cyc_q.size(), 0);
      chk("sym_queue_drained", sym_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
